// File: rtl/operand_fetch.sv
// Operand fetch stage: holds one decoded instruction until its sources are free,
// reads the register file (with writeback bypass) and hands operands to execute.
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic              in_use_rs,
    input  logic              in_use_rt,
    output logic [4:0]        grf_a1,
    output logic [4:0]        grf_a2,
    input  logic [DATA_W-1:0] grf_rd1,
    input  logic [DATA_W-1:0] grf_rd2,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_rs_val,
    output logic [DATA_W-1:0] out_rt_val,
    output logic [4:0]        out_rd,
    output logic [31:0]       busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        OUT   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         slot_pc_q, slot_pc_d;
    logic [4:0]          slot_rs_q, slot_rs_d;
    logic [4:0]          slot_rt_q, slot_rt_d;
    logic [4:0]          slot_rd_q, slot_rd_d;
    logic                slot_use_rs_q, slot_use_rs_d;
    logic                slot_use_rt_q, slot_use_rt_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_pc_q, out_pc_d;
    logic [DATA_W-1:0]   out_rs_val_q, out_rs_val_d;
    logic [DATA_W-1:0]   out_rt_val_q, out_rt_val_d;
    logic [4:0]          out_rd_q, out_rd_d;
    logic [31:0]         busy_q, busy_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic accept_s;
    logic haz_rs_s, haz_rt_s, haz_waw_s, hazard_s;

    function automatic logic wb_hit(input logic we, input logic [4:0] waddr, input logic [4:0] r);
        return we & (waddr == r) & (r != 5'd0);
    endfunction

    // r0 reads as zero; a same-cycle writeback overrides the stale register file value
    function automatic logic [DATA_W-1:0] pick_operand(input logic [4:0] r, input logic hit,
                                                       input logic [DATA_W-1:0] bypass,
                                                       input logic [DATA_W-1:0] rf);
        if (r == 5'd0)
            return '0;
        else if (hit)
            return bypass;
        else
            return rf;
    endfunction

    assign in_ready = (state_q == IDLE) | ((state_q == OUT) & out_ready);
    assign accept_s = in_valid & in_ready;

    assign haz_rs_s  = slot_use_rs_q & (slot_rs_q != 5'd0) & busy_q[slot_rs_q]
                       & ~wb_hit(wb_we, wb_addr, slot_rs_q);
    assign haz_rt_s  = slot_use_rt_q & (slot_rt_q != 5'd0) & busy_q[slot_rt_q]
                       & ~wb_hit(wb_we, wb_addr, slot_rt_q);
    assign haz_waw_s = (slot_rd_q != 5'd0) & busy_q[slot_rd_q]
                       & ~wb_hit(wb_we, wb_addr, slot_rd_q);
    assign hazard_s  = haz_rs_s | haz_rt_s | haz_waw_s;

    // Next-state, slot capture, scoreboard and output-register logic
    always_comb begin
        state_d       = state_q;
        slot_pc_d     = slot_pc_q;
        slot_rs_d     = slot_rs_q;
        slot_rt_d     = slot_rt_q;
        slot_rd_d     = slot_rd_q;
        slot_use_rs_d = slot_use_rs_q;
        slot_use_rt_d = slot_use_rt_q;
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_rs_val_d  = out_rs_val_q;
        out_rt_val_d  = out_rt_val_q;
        out_rd_d      = out_rd_q;
        busy_d        = busy_q;
        stall_cnt_d   = stall_cnt_q;

        if (accept_s) begin
            slot_pc_d     = in_pc;
            slot_rs_d     = in_rs;
            slot_rt_d     = in_rt;
            slot_rd_d     = in_rd;
            slot_use_rs_d = in_use_rs;
            slot_use_rt_d = in_use_rt;
        end else begin
            slot_pc_d = slot_pc_q;
        end

        // Clear first so that an issuing producer's set below takes priority
        if (wb_we && (wb_addr != 5'd0)) begin
            busy_d[wb_addr] = 1'b0;
        end else begin
            busy_d = busy_q;
        end

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = CHECK;
                end else begin
                    state_d = IDLE;
                end
            end
            CHECK: begin
                if (hazard_s) begin
                    if (stall_cnt_q != {CNT_W{1'b1}}) begin
                        stall_cnt_d = stall_cnt_q + CNT_W'(1);
                    end else begin
                        stall_cnt_d = stall_cnt_q;
                    end
                end else begin
                    out_rs_val_d = pick_operand(slot_rs_q, wb_hit(wb_we, wb_addr, slot_rs_q),
                                                wb_data, grf_rd1);
                    out_rt_val_d = pick_operand(slot_rt_q, wb_hit(wb_we, wb_addr, slot_rt_q),
                                                wb_data, grf_rd2);
                    out_pc_d     = slot_pc_q;
                    out_rd_d     = slot_rd_q;
                    if (slot_rd_q != 5'd0) begin
                        busy_d[slot_rd_q] = 1'b1;
                    end else begin
                        busy_d[0] = 1'b0;
                    end
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = accept_s ? CHECK : IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        busy_d[0] = 1'b0;
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            slot_pc_q     <= 32'd0;
            slot_rs_q     <= 5'd0;
            slot_rt_q     <= 5'd0;
            slot_rd_q     <= 5'd0;
            slot_use_rs_q <= 1'b0;
            slot_use_rt_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_pc_q      <= 32'd0;
            out_rs_val_q  <= '0;
            out_rt_val_q  <= '0;
            out_rd_q      <= 5'd0;
            busy_q        <= 32'd0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            slot_pc_q     <= slot_pc_d;
            slot_rs_q     <= slot_rs_d;
            slot_rt_q     <= slot_rt_d;
            slot_rd_q     <= slot_rd_d;
            slot_use_rs_q <= slot_use_rs_d;
            slot_use_rt_q <= slot_use_rt_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_rs_val_q  <= out_rs_val_d;
            out_rt_val_q  <= out_rt_val_d;
            out_rd_q      <= out_rd_d;
            busy_q        <= busy_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign grf_a1     = slot_rs_q;
    assign grf_a2     = slot_rt_q;
    assign out_valid  = out_valid_q;
    assign out_pc     = out_pc_q;
    assign out_rs_val = out_rs_val_q;
    assign out_rt_val = out_rt_val_q;
    assign out_rd     = out_rd_q;
    assign busy       = busy_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed instructions push expected issue
// records; a negedge monitor pops and compares on every execute handshake.
module tb_operand_fetch;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, in_ready;
    logic [31:0]       in_pc;
    logic [4:0]        in_rs, in_rt, in_rd;
    logic              in_use_rs, in_use_rt;
    logic [4:0]        grf_a1, grf_a2;
    logic [DATA_W-1:0] grf_rd1, grf_rd2;
    logic              wb_we;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid, out_ready;
    logic [31:0]       out_pc;
    logic [DATA_W-1:0] out_rs_val, out_rt_val;
    logic [4:0]        out_rd;
    logic [31:0]       busy;
    logic [CNT_W-1:0]  stall_cnt;

    typedef struct packed {
        logic [31:0]       pc;
        logic [DATA_W-1:0] rs_val;
        logic [DATA_W-1:0] rt_val;
        logic [4:0]        rd;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    operand_fetch #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
        .grf_a1(grf_a1), .grf_a2(grf_a2), .grf_rd1(grf_rd1), .grf_rd2(grf_rd2),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs_val(out_rs_val), .out_rt_val(out_rt_val), .out_rd(out_rd),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer an instruction and return 1 time unit after the accepting edge
    task automatic issue(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic urs, input logic urt);
        bit ok = 1'b0;
        in_valid = 1'b1; in_pc = pc; in_rs = rs; in_rt = rt; in_rd = rd;
        in_use_rs = urs; in_use_rt = urt;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: pc 0x%0h not accepted within 20 cycles", pc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every execute handshake must match the oldest expected record
    always @(negedge clk) begin
        exp_t e;
        if (reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_issue: got pc 0x%0h required none", out_pc);
            end else begin
                e = sb_q.pop_front();
                check("issue", {out_pc, out_rs_val, out_rt_val, out_rd}, e);
            end
        end
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_pc = 32'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0;
        in_use_rs = 1'b0; in_use_rt = 1'b0; grf_rd1 = 32'd0; grf_rd2 = 32'd0;
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; out_ready = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 32'd0);
        check("rst_stall", stall_cnt, 16'd0);
        check("rst_grf_a", {grf_a1, grf_a2}, 10'd0);
        check("rst_out_pc", out_pc, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1 check("idle_in_ready", in_ready, 1'b1);

        // Plain issue, 2-edge latency, busy[3] set
        grf_rd1 = 32'h11; grf_rd2 = 32'h22;
        sb_q.push_back('{pc: 32'h3000, rs_val: 32'h11, rt_val: 32'h22, rd: 5'd3});
        issue(32'h3000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
        check("t1_grf_a", {grf_a1, grf_a2}, {5'd1, 5'd2});
        check("t1_not_yet_valid", out_valid, 1'b0);
        tick(1);
        check("t1_valid", out_valid, 1'b1);
        check("t1_busy", busy, 32'h0000_0008);

        // RAW stall on r3, resolved by same-cycle writeback bypass
        sb_q.push_back('{pc: 32'h3004, rs_val: 32'hABCD, rt_val: 32'h0, rd: 5'd0});
        issue(32'h3004, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0);
        tick(3);
        check("t2_stall_cnt", stall_cnt, 16'd3);
        check("t2_stalled", out_valid, 1'b0);
        grf_rd1 = 32'h5555; wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hABCD;
        tick(1);
        wb_we = 1'b0;
        check("t2_valid", out_valid, 1'b1);
        check("t2_busy_cleared", busy, 32'd0);
        check("t2_stall_hold", stall_cnt, 16'd3);

        // WAW on r5: clear and set on the same edge leaves busy[5]=1
        sb_q.push_back('{pc: 32'h3008, rs_val: 32'h0, rt_val: 32'h0, rd: 5'd5});
        issue(32'h3008, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
        tick(1);
        check("t3_busy5", busy, 32'h0000_0020);
        grf_rd1 = 32'h101; grf_rd2 = 32'h202;
        sb_q.push_back('{pc: 32'h300C, rs_val: 32'h101, rt_val: 32'h202, rd: 5'd5});
        issue(32'h300C, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
        tick(2);
        check("t3_waw_stall", stall_cnt, 16'd5);
        check("t3_stalled", out_valid, 1'b0);
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h77;
        tick(1);
        wb_we = 1'b0;
        check("t3_valid", out_valid, 1'b1);
        check("t3_set_wins", busy, 32'h0000_0020);

        // r0 source reads zero; writeback to r0 leaves the scoreboard alone
        grf_rd1 = 32'hDEAD; grf_rd2 = 32'h2222;
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h99;
        sb_q.push_back('{pc: 32'h3010, rs_val: 32'h0, rt_val: 32'h2222, rd: 5'd0});
        issue(32'h3010, 5'd0, 5'd2, 5'd0, 1'b1, 1'b1);
        check("t4_busy_wb0", busy, 32'h0000_0020);
        tick(1);
        wb_we = 1'b0;
        check("t4_valid", out_valid, 1'b1);
        check("t4_busy", busy, 32'h0000_0020);
        check("t4_stall", stall_cnt, 16'd5);

        // Back-pressure: outputs hold while out_ready is low
        grf_rd1 = 32'h44; grf_rd2 = 32'h66;
        sb_q.push_back('{pc: 32'h3014, rs_val: 32'h44, rt_val: 32'h66, rd: 5'd7});
        issue(32'h3014, 5'd4, 5'd6, 5'd7, 1'b1, 1'b1);
        out_ready = 1'b0;
        tick(1);
        check("t5_valid", out_valid, 1'b1);
        check("t5_busy", busy, 32'h0000_00A0);
        grf_rd1 = 32'hBAD;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("t5_hold", {out_valid, out_pc, out_rs_val, out_rt_val, out_rd, in_ready},
                  {1'b1, 32'h3014, 32'h44, 32'h66, 5'd7, 1'b0});
        end
        in_valid = 1'b1; in_pc = 32'h3018; in_rs = 5'd7; in_rt = 5'd0; in_rd = 5'd0;
        in_use_rs = 1'b1; in_use_rt = 1'b0; out_ready = 1'b1;
        #1 check("t5_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("t5_in_check", {out_valid, in_ready}, 2'b00);
        tick(1);
        check("t5_raw_stall", stall_cnt, 16'd6);

        // Asynchronous reset in the middle of a stalled CHECK
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("t6_async_valid", out_valid, 1'b0);
        check("t6_async_busy", busy, 32'd0);
        check("t6_async_stall", stall_cnt, 16'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("t6_idle_ready", in_ready, 1'b1);
        check("t6_grf_a", {grf_a1, grf_a2}, 10'd0);
        tick(2);
        check("scoreboard_drain", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
